// File: rtl/pwm_pkg.sv
// Purpose : shared PWM definitions (fade FSM states, default bus widths).
// Latency : n/a (types and constants only).
// Backpr. : n/a.
// Contents: PWM_BW/PWM_DW default widths, fade_state_t {ST_IDLE, ST_FADE}.
package pwm_pkg;

   localparam int PWM_BW = 8;   // duty / max_value / target / step width
   localparam int PWM_DW = 8;   // dwell width (periods per step, minus 1)

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_FADE = 1'b1
   } fade_state_t;

endpackage

// File: rtl/pwm_period_timer.sv
// Purpose : free-running PWM period counter, 0..max_value, with end-of-period tick.
// Latency : period_tick is combinational from the counter register.
// Backpr. : none; enable=0 freezes the counter and suppresses the tick.
// Ports   : clk, rst (sync, active-high), enable, max_value[BW] in;
//           period_tick out (high on the last cycle of each period).
module pwm_period_timer
   import pwm_pkg::*;
#(
   parameter int BW = PWM_BW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          enable,
   input  logic [BW-1:0] max_value,
   output logic          period_tick
);

   logic [BW-1:0] pc;

   assign period_tick = enable && (pc == max_value);

   // >= rather than == keeps the counter bounded even if max_value were
   // ever lowered below the current count.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc <= '0;
      end else if (enable) begin
         if (pc >= max_value) pc <= '0;
         else                 pc <= pc + 1'b1;
      end
   end

endmodule

// File: rtl/pwm_fade_ctrl.sv
// Purpose : ramps one PWM channel's duty toward a commanded target, one step
//           every (dwell+1) PWM periods, updating duty/max_value only at period ends.
// Latency : first duty change on the (dwell+1)-th period_tick after accept.
// Backpr. : cmd_ready=0 while a fade runs (default build).
// Ports   : clk, rst (sync, active-high), enable, cfg_max, cmd_valid/cmd_ready,
//           cmd_target, cmd_step, cmd_dwell in; duty, max_value, period_tick,
//           busy, done out.
// Option  : PWM_FADE_BREATHE_EN -- endless tgt<->0 breathing, commands preempt.
module pwm_fade_ctrl
   import pwm_pkg::*;
#(
   parameter int            BW          = PWM_BW,
   parameter int            DW          = PWM_DW,
   parameter logic [BW-1:0] DEFAULT_MAX = '1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          enable,
   input  logic [BW-1:0] cfg_max,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [BW-1:0] cmd_target,
   input  logic [BW-1:0] cmd_step,
   input  logic [DW-1:0] cmd_dwell,
   output logic [BW-1:0] duty,
   output logic [BW-1:0] max_value,
   output logic          period_tick,
   output logic          busy,
   output logic          done
);

   fade_state_t   state, state_nxt;
   logic [BW-1:0] tgt, tgt_nxt, stp, stp_nxt, new_max, new_max_nxt;
   logic [BW-1:0] duty_nxt, max_nxt, goal, stepped;
   logic [DW-1:0] dwl, dwl_nxt, dwell_cnt, dwell_cnt_nxt;
   logic          first, first_nxt, done_nxt;
   logic [BW:0]   duty_x, goal_x, stp_x, gap;
   logic          up;

   pwm_period_timer #(.BW(BW)) u_timer (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .max_value   (max_value),
      .period_tick (period_tick)
   );

   assign busy = (state == ST_FADE);

`ifdef PWM_FADE_BREATHE_EN
   logic dir_down, dir_down_nxt;
   assign goal      = dir_down ? '0 : tgt;
   assign cmd_ready = 1'b1;

   always_ff @(posedge clk) begin
      if (rst) dir_down <= 1'b0;
      else     dir_down <= dir_down_nxt;
   end
`else
   assign goal      = tgt;
   assign cmd_ready = (state == ST_IDLE);
`endif

   // Saturating step toward goal. Distance and compare are done one bit wider
   // so the gap never wraps; the add/sub itself only runs when the result lies
   // strictly between duty and goal, so it cannot overflow or underflow.
   always_comb begin
      duty_x = {1'b0, duty};
      goal_x = {1'b0, goal};
      stp_x  = {1'b0, stp};
      up     = (goal_x > duty_x);
      gap    = up ? (goal_x - duty_x) : (duty_x - goal_x);
      if (gap <= stp_x) stepped = goal;
      else if (up)      stepped = duty + stp;
      else              stepped = duty - stp;
   end

   always_comb begin
      state_nxt     = state;
      duty_nxt      = duty;
      max_nxt       = max_value;
      tgt_nxt       = tgt;
      stp_nxt       = stp;
      dwl_nxt       = dwl;
      new_max_nxt   = new_max;
      dwell_cnt_nxt = dwell_cnt;
      first_nxt     = first;
      done_nxt      = 1'b0;
`ifdef PWM_FADE_BREATHE_EN
      dwell_cnt_nxt = dwell_cnt;
      dir_down_nxt  = dir_down;
`endif
      // Accept wins over a coincident tick, so that tick is never counted.
      if (cmd_valid && cmd_ready) begin
         tgt_nxt       = (cmd_target > cfg_max) ? cfg_max : cmd_target;
         stp_nxt       = (cmd_step != '0) ? cmd_step : {{(BW-1){1'b0}}, 1'b1};
         dwl_nxt       = cmd_dwell;
         new_max_nxt   = cfg_max;
         dwell_cnt_nxt = cmd_dwell;
         first_nxt     = 1'b1;
         state_nxt     = ST_FADE;
`ifdef PWM_FADE_BREATHE_EN
         dir_down_nxt  = 1'b0;
`endif
      end else if ((state == ST_FADE) && period_tick) begin
         // New max_value lands at a period boundary; the counter wraps here too.
         if (first) begin
            max_nxt   = new_max;
            first_nxt = 1'b0;
         end
         if (dwell_cnt != '0) begin
            dwell_cnt_nxt = dwell_cnt - 1'b1;
         end else begin
            dwell_cnt_nxt = dwl;
            duty_nxt      = stepped;
            if (stepped == goal) begin
`ifdef PWM_FADE_BREATHE_EN
               if (!dir_down) done_nxt = 1'b1;
               dir_down_nxt = !dir_down;
`else
               done_nxt  = 1'b1;
               state_nxt = ST_IDLE;
`endif
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         duty      <= '0;
         max_value <= DEFAULT_MAX;
         tgt       <= '0;
         stp       <= '0;
         dwl       <= '0;
         new_max   <= '0;
         dwell_cnt <= '0;
         first     <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         duty      <= duty_nxt;
         max_value <= max_nxt;
         tgt       <= tgt_nxt;
         stp       <= stp_nxt;
         dwl       <= dwl_nxt;
         new_max   <= new_max_nxt;
         dwell_cnt <= dwell_cnt_nxt;
         first     <= first_nxt;
         done      <= done_nxt;
      end
   end

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Purpose : self-checking bench for pwm_fade_ctrl (default one-shot build).
// Latency : n/a.
// Backpr. : n/a.
module tb_pwm_fade_ctrl;

   logic       clk = 1'b0;
   logic       rst, enable, cmd_valid;
   logic [7:0] cfg_max, cmd_target, cmd_step, cmd_dwell;
   logic       cmd_ready, period_tick, busy, done;
   logic [7:0] duty, max_value;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pwm_fade_ctrl #(.BW(8), .DW(8), .DEFAULT_MAX(8'hFF)) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .cfg_max     (cfg_max),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_target  (cmd_target),
      .cmd_step    (cmd_step),
      .cmd_dwell   (cmd_dwell),
      .duty        (duty),
      .max_value   (max_value),
      .period_tick (period_tick),
      .busy        (busy),
      .done        (done)
   );

   // Reference model: a phase counter per period, and on accept the whole
   // list of duty values the fade will pass through, popped one per update.
   int m_pc, m_max, m_duty, m_newmax, m_dw, m_ticks, m_first;
   bit m_busy, m_done;
   int q[$];
   int done_seen;

   function automatic int toward(input int cur, input int t, input int s);
      if (cur < t) return (t - cur <= s) ? t : cur + s;
      else         return (cur - t <= s) ? t : cur - s;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_accept();
      int cur, t, s;
      cur = m_duty;
      t   = (cmd_target > cfg_max) ? int'(cfg_max) : int'(cmd_target);
      s   = (cmd_step == 0) ? 1 : int'(cmd_step);
      q.delete();
      if (cur == t) q.push_back(cur);
      else while (cur != t) begin
         cur = toward(cur, t, s);
         q.push_back(cur);
      end
      m_newmax = cfg_max;
      m_dw     = cmd_dwell;
      m_ticks  = 0;
      m_first  = 1;
      m_busy   = 1;
   endtask

   task automatic model_reset();
      m_pc = 0; m_max = 255; m_duty = 0; m_busy = 0; m_done = 0; m_first = 0;
      q.delete();
   endtask

   // One clock: compare all outputs at the negedge, then advance the model
   // with the inputs seen at the posedge.
   task automatic cyc();
      bit t;
      @(negedge clk);
      t = enable && (m_pc == m_max);
      check("duty",        duty,        m_duty);
      check("max_value",   max_value,   m_max);
      check("period_tick", period_tick, t);
      check("busy",        busy,        m_busy);
      check("done",        done,        m_done);
      check("cmd_ready",   cmd_ready,   !m_busy);
      if (done === 1'b1) done_seen++;
      @(posedge clk);
      m_done = 0;
      if (rst) begin
         model_reset();
      end else begin
         if (cmd_valid && !m_busy) begin
            model_accept();
         end else if (m_busy && t) begin
            m_ticks++;
            if (m_first != 0) begin
               m_max   = m_newmax;
               m_first = 0;
            end
            if (m_ticks % (m_dw + 1) == 0) begin
               m_duty = q.pop_front();
               if (q.size() == 0) begin
                  m_done = 1;
                  m_busy = 0;
               end
            end
         end
         if (enable) m_pc = t ? 0 : m_pc + 1;
      end
      #1;
   endtask

   task automatic issue(input int cm, input int tg, input int st, input int dw);
      cfg_max    = 8'(cm);
      cmd_target = 8'(tg);
      cmd_step   = 8'(st);
      cmd_dwell  = 8'(dw);
      cmd_valid  = 1'b1;
      cyc();
      cmd_valid  = 1'b0;
      // Scramble the command bus: only the accepted values may matter.
      cfg_max    = 8'($urandom_range(0, 255));
      cmd_target = 8'($urandom_range(0, 255));
      cmd_step   = 8'($urandom_range(0, 255));
      cmd_dwell  = 8'($urandom_range(0, 255));
   endtask

   task automatic run_to_idle(input bit rand_en);
      for (int c = 0; c < 30000 && m_busy; c++) begin
         if (rand_en) enable = ($urandom_range(0, 9) != 0);
         cyc();
      end
      enable = 1'b1;
      check("fade_timeout", m_busy, 0);
      cyc();
   endtask

   initial begin
      rst = 1'b1; enable = 1'b1; cmd_valid = 1'b0;
      cfg_max = '0; cmd_target = '0; cmd_step = '0; cmd_dwell = '0;
      @(posedge clk);
      #1;
      model_reset();
      cyc();
      rst = 1'b0;

      // 1: idle after reset, 256-cycle periods
      check("rst_duty", duty, 0);
      check("rst_max", max_value, 255);
      check("rst_ready", cmd_ready, 1);
      for (int i = 0; i < 600; i++) cyc();

      // 2: ramp up 2,4,6 with new max 9
      done_seen = 0;
      issue(9, 6, 2, 0);
      run_to_idle(1'b0);
      check("t2_done_once", done_seen, 1);
      check("t2_duty", duty, 6);
      check("t2_max", max_value, 9);

      // 3: ramp down with saturation at 0, every 2nd tick
      issue(9, 0, 4, 1);
      run_to_idle(1'b0);
      check("t3_duty", duty, 0);

      // 4: target clamped to cfg_max, step 0 acts as 1
      done_seen = 0;
      issue(100, 200, 0, 0);
      run_to_idle(1'b0);
      check("t4_duty", duty, 100);
      check("t4_done_once", done_seen, 1);

      // 5: enable low mid-fade, then reset mid-fade
      issue(20, 15, 1, 2);
      for (int i = 0; i < 120; i++) cyc();
      enable = 1'b0;
      for (int i = 0; i < 50; i++) cyc();
      enable = 1'b1;
      for (int i = 0; i < 60; i++) cyc();
      check("t5_busy_mid", busy, 1);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      cyc();
      check("t5_rst_duty", duty, 0);
      check("t5_rst_max", max_value, 255);
      check("t5_rst_busy", busy, 0);

      // equal target: done with no duty change
      issue(255, 0, 3, 0);
      run_to_idle(1'b0);
      check("eq_duty", duty, 0);

      // random fades with random enable gaps
      for (int n = 0; n < 20; n++) begin
         issue($urandom_range(0, 15), $urandom_range(0, 255),
               $urandom_range(0, 5), $urandom_range(0, 3));
         run_to_idle(1'b1);
         for (int i = 0; i < int'($urandom_range(0, 5)); i++) cyc();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
